// File: rtl/led_adc_scheduler.sv
// led_adc_scheduler: LED / ADC slot sequencer for the IR and red channels.
//   The IR and red LEDs take turns in fixed slots of PHASE_CYC cycles.
//   In each slot the sequencer waits SETTLE_CYC cycles, requests one ADC
//   conversion and routes the result to the matching filter input with a
//   one-cycle strobe. A conversion that does not finish in time sets a
//   sticky error flag.
// Build option: define LED_PWRSAVE_EN to switch the LED off for the rest of
//   the slot once the sample has been taken or has timed out.
// Ports:
//   CLK, rst               clock; synchronous active-high reset
//   enable                 run sequencing; sampled at slot boundaries
//   adc_done, adc_data     conversion-complete pulse and its result
//   led_ir_on, led_red_on  LED drives (never on together)
//   adc_start              one-cycle conversion request
//   IR_ADC_Value/ir_strobe, RED_ADC_Value/red_strobe  captured samples
//   adc_timeout_err        sticky conversion-timeout flag
//   slot_is_ir             1 during the IR slot
module led_adc_scheduler #(
  parameter int unsigned PHASE_CYC   = 50,
  parameter int unsigned SETTLE_CYC  = 10,
  parameter int unsigned ADC_TIMEOUT = 20,
  parameter int unsigned ADC_W       = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             enable,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic             led_ir_on,
  output logic             led_red_on,
  output logic             adc_start,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic             ir_strobe,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic             red_strobe,
  output logic             adc_timeout_err,
  output logic             slot_is_ir
);

  localparam int unsigned CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(SETTLE_CYC);
  // Last cycle in which adc_done is accepted; the error shows ADC_TIMEOUT
  // cycles after adc_start.
  localparam logic [CNT_W-1:0] TO_CNT    = CNT_W'(SETTLE_CYC + ADC_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CONV, HOLD} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ir_nx;
  logic             capture_c;
  logic             timeout_c;
  logic             led_nx;
  logic             start_nx;

  // Next slot position, state and channel.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ir_nx     = slot_is_ir;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    if (state == IDLE) begin
      if (enable) begin
        state_nx = SETTLE;
        cnt_nx   = '0;
        ir_nx    = 1'b1;
      end
    end else begin
      cnt_nx = cnt + CNT_W'(1);
      if (state == SETTLE && cnt == START_CNT) begin
        state_nx = CONV;
      end
      if (state == CONV) begin
        if (adc_done) begin
          capture_c = 1'b1;
          state_nx  = HOLD;
        end else if (cnt == TO_CNT) begin
          timeout_c = 1'b1;
          state_nx  = HOLD;
        end
      end
      if (cnt == LAST_CNT) begin
        cnt_nx = '0;
        if (enable) begin
          state_nx = SETTLE;
          ir_nx    = ~slot_is_ir;
        end else begin
          state_nx = IDLE;
          ir_nx    = 1'b0;
        end
      end
    end
  end

  // LED is dark at cnt=0 of every slot (break-before-make).
  always_comb begin
`ifdef LED_PWRSAVE_EN
    led_nx = (state_nx != IDLE) && (cnt_nx != '0) &&
             !((state == HOLD) && (state_nx == HOLD));
`else
    led_nx = (state_nx != IDLE) && (cnt_nx != '0);
`endif
    start_nx = (state_nx == SETTLE) && (cnt_nx == START_CNT);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      slot_is_ir      <= 1'b0;
      led_ir_on       <= 1'b0;
      led_red_on      <= 1'b0;
      adc_start       <= 1'b0;
      IR_ADC_Value    <= '0;
      ir_strobe       <= 1'b0;
      RED_ADC_Value   <= '0;
      red_strobe      <= 1'b0;
      adc_timeout_err <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      slot_is_ir <= ir_nx;
      led_ir_on  <= led_nx && ir_nx;
      led_red_on <= led_nx && !ir_nx;
      adc_start  <= start_nx;
      ir_strobe  <= capture_c && slot_is_ir;
      red_strobe <= capture_c && !slot_is_ir;
      if (capture_c && slot_is_ir) begin
        IR_ADC_Value <= adc_data;
      end
      if (capture_c && !slot_is_ir) begin
        RED_ADC_Value <= adc_data;
      end
      if (timeout_c) begin
        adc_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_adc_scheduler.sv
// Bench for led_adc_scheduler (PHASE_CYC=20, SETTLE_CYC=4, ADC_TIMEOUT=6).
module tb_led_adc_scheduler;

  localparam int P = 20;
  localparam int S = 4;
  localparam int T = 6;
`ifdef LED_PWRSAVE_EN
  localparam bit PWR = 1'b1;
`else
  localparam bit PWR = 1'b0;
`endif

  logic       CLK;
  logic       rst;
  logic       enable;
  logic       adc_done;
  logic [7:0] adc_data;
  logic       led_ir_on, led_red_on, adc_start;
  logic [7:0] IR_ADC_Value, RED_ADC_Value;
  logic       ir_strobe, red_strobe, adc_timeout_err, slot_is_ir;

  led_adc_scheduler #(
    .PHASE_CYC(P), .SETTLE_CYC(S), .ADC_TIMEOUT(T), .ADC_W(8)
  ) dut (
    .CLK(CLK), .rst(rst), .enable(enable), .adc_done(adc_done),
    .adc_data(adc_data), .led_ir_on(led_ir_on), .led_red_on(led_red_on),
    .adc_start(adc_start), .IR_ADC_Value(IR_ADC_Value), .ir_strobe(ir_strobe),
    .RED_ADC_Value(RED_ADC_Value), .red_strobe(red_strobe),
    .adc_timeout_err(adc_timeout_err), .slot_is_ir(slot_is_ir)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: position within the slot, channel, and whether this
  // slot's conversion has already resolved (sample or timeout).
  bit       m_act, m_ir, m_res, m_err, m_sir, m_sred;
  int       m_pos, m_res_pos;
  logic [7:0] m_irv, m_redv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] model_vec();
    bit led;
    led = m_act && (m_pos != 0) && !(PWR && m_res && (m_pos > m_res_pos));
    return {led && m_ir, led && !m_ir, m_act && (m_pos == S), m_irv, m_sir,
            m_redv, m_sred, m_err, m_act && m_ir};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {led_ir_on, led_red_on, adc_start, IR_ADC_Value, ir_strobe,
            RED_ADC_Value, red_strobe, adc_timeout_err, slot_is_ir};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_act = 0; m_ir = 0; m_res = 0; m_err = 0; m_sir = 0; m_sred = 0;
      m_pos = 0; m_res_pos = 0; m_irv = 8'h00; m_redv = 8'h00;
    end else if (!m_act) begin
      m_sir = 0; m_sred = 0;
      if (enable) begin
        m_act = 1; m_pos = 0; m_ir = 1; m_res = 0;
      end
    end else begin
      m_sir = 0; m_sred = 0;
      if (!m_res && m_pos >= S + 1 && m_pos <= S + T - 1 && adc_done) begin
        if (m_ir) begin m_irv = adc_data; m_sir = 1; end
        else begin m_redv = adc_data; m_sred = 1; end
        m_res = 1; m_res_pos = m_pos + 1;
      end else if (!m_res && m_pos == S + T - 1) begin
        m_err = 1; m_res = 1; m_res_pos = m_pos + 1;
      end
      if (m_pos == P - 1) begin
        m_pos = 0; m_res = 0;
        if (enable) m_ir = !m_ir;
        else begin m_act = 0; m_ir = 0; end
      end else begin
        m_pos++;
      end
    end
  endtask

  // One clock: advance the model on the edge, compare every output after it.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Drive one whole slot from its cnt=0 cycle. delay: adc_done this many
  // cycles after adc_start (0 = never). stray: extra done at that position.
  task automatic run_slot(input int delay, input logic [7:0] data, input int stray,
                          input logic [7:0] stray_data, input int drop_at,
                          output int spos);
    spos = -1;
    for (int i = 0; i < P; i++) begin
      if (m_pos == drop_at) enable = 1'b0;
      adc_done = 1'b0;
      adc_data = 8'h00;
      if (delay != 0 && m_pos == S + delay) begin
        adc_done = 1'b1; adc_data = data;
      end else if (m_pos == stray) begin
        adc_done = 1'b1; adc_data = stray_data;
      end
      tick();
      if (ir_strobe || red_strobe) spos = m_pos;
    end
    adc_done = 1'b0;
  endtask

  typedef struct {
    int         delay;
    logic [7:0] data;
    int         stray;
    logic [7:0] exp_ir;
    logic [7:0] exp_red;
    bit         exp_err;
    int         exp_spos;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int spos;
    int guard;
    tbl[0] = '{3, 8'hA5, -1, 8'hA5, 8'h00, 1'b0, 8};
    tbl[1] = '{3, 8'h20, -1, 8'hA5, 8'h20, 1'b0, 8};
    tbl[2] = '{3, 8'h30,  2, 8'h30, 8'h20, 1'b0, 8};
    tbl[3] = '{0, 8'h00, -1, 8'h30, 8'h20, 1'b1, -1};
    tbl[4] = '{5, 8'h40, -1, 8'h40, 8'h20, 1'b1, 10};
    tbl[5] = '{1, 8'h5A, -1, 8'h40, 8'h5A, 1'b1, 6};
    tbl[6] = '{3, 8'hC3, 15, 8'hC3, 8'h5A, 1'b1, 8};

    rst = 1'b1; enable = 1'b0; adc_done = 1'b0; adc_data = 8'h00;
    m_act = 0; m_ir = 0; m_res = 0; m_err = 0; m_sir = 0; m_sred = 0;
    m_pos = 0; m_res_pos = 0; m_irv = 8'h00; m_redv = 8'h00;
    tick();
    tick();
    chk("reset_all_zero", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_stays_dark", 32'({led_ir_on, led_red_on, adc_start}), 32'd0);

    // Table-driven slots starting with IR.
    enable = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      run_slot(tbl[k].delay, tbl[k].data, tbl[k].stray, 8'hFF, -1, spos);
      chk($sformatf("slot%0d_ir_value", k), 32'(IR_ADC_Value), 32'(tbl[k].exp_ir));
      chk($sformatf("slot%0d_red_value", k), 32'(RED_ADC_Value), 32'(tbl[k].exp_red));
      chk($sformatf("slot%0d_timeout_err", k), 32'(adc_timeout_err), 32'(tbl[k].exp_err));
      chk($sformatf("slot%0d_strobe_pos", k), 32'(spos), 32'(tbl[k].exp_spos));
    end

    // Randomized slots with random stray done pulses.
    for (int k = 0; k < 16; k++) begin
      int d;
      int st;
      d  = int'($urandom_range(0, 7));
      st = int'($urandom_range(0, 25));
      run_slot(d, 8'($urandom), st, 8'($urandom), -1, spos);
    end

    // Stop: drop enable at cnt=7 of an IR slot.
    guard = 0;
    while (!(m_act && m_ir && m_pos == 0) && guard < 200) begin
      tick();
      guard++;
    end
    chk("wait_ir_slot_in_time", 32'(guard < 200), 32'd1);
    run_slot(3, 8'h66, -1, 8'h00, 7, spos);
    chk("stop_slot_completed_strobe", 32'(spos), 32'd8);
    for (int i = 0; i < 5; i++) tick();
    chk("stop_idle_dark", 32'({led_ir_on, led_red_on, slot_is_ir, adc_start}), 32'd0);
    chk("stop_keeps_ir_value", 32'(IR_ADC_Value), 32'h66);

    // Re-enable, reset mid-conversion, then a late adc_done.
    enable = 1'b1;
    tick();
    chk("restart_in_ir_slot", 32'(slot_is_ir), 32'd1);
    guard = 0;
    while (m_pos != S + 1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("wait_conv_in_time", 32'(guard < 50), 32'd1);
    rst = 1'b1; enable = 1'b0;
    tick();
    chk("midconv_reset_zero", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    tick();
    adc_done = 1'b1; adc_data = 8'h77;
    tick();
    adc_done = 1'b0; adc_data = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    chk("late_done_ignored", 32'(dut_vec()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
